data_mem_access_unit: RTL and testbench

MEM-stage responder for the memory control fields produced by the ID-stage decoder: mem_read[3:0] (enable + funct3) and mem_write[2:0] (enable + size). It turns each load or store into one handshaked word transaction on the data-memory bus and stalls the pipeline while the transaction is in flight. It also generates byte enables and aligned write data, and sign/zero-extends load data. Misaligned accesses and bus timeouts are flagged.

---
 rtl/data_mem_access_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_access_unit.sv
// -----------------------------------------------------------------------------
// data_mem_access_unit
//
// MEM-stage responder for the decoder's memory control fields. Each aligned
// load or store becomes one handshaked word transaction on the data-memory
// bus. The pipeline is stalled while the transaction is in flight. The unit
// builds byte enables and lane-replicated store data, and it sign- or
// zero-extends load data. Misaligned requests are rejected with a one-cycle
// pulse. A transaction that gets no ack within TIMEOUT_CYCLES is abandoned
// with a one-cycle bus error pulse.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   mem_read[3:0]  in   [3]=load enable, [2:0]=funct3
//   mem_write[2:0] in   [2]=store enable, [1:0]=size (00 B, 01 H, 10 W)
//   address[31:0]  in   byte address from the ALU
//   write_data     in   store data (rs2)
//   read_data      out  extended load result, valid from DONE
//   busy           out  combinational stall request
//   misaligned_err out  pulse: request rejected for misalignment
//   bus_err        out  pulse (in DONE): transaction timed out
//   mem_req        out  bus request, high throughout ACCESS
//   mem_we         out  1=write, 0=read
//   mem_addr[29:0] out  word address
//   mem_byte_en    out  byte lanes
//   mem_wdata      out  lane-replicated store data
//   mem_rdata      in   bus read word
//   mem_ack        in   bus completion, one cycle
// -----------------------------------------------------------------------------
module data_mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  mem_read,
   input  logic [2:0]  mem_write,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        busy,
   output logic        misaligned_err,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_byte_en,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // Last ACCESS cycle that may still wait for an ack.
   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [31:0] read_data_q, read_data_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [29:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_byte_en_q, mem_byte_en_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  lane_q, lane_d;
   logic [7:0]  count_q, count_d;
   logic        bus_err_q, bus_err_d;

   // Request decode (IDLE inputs)
   logic        st_req;
   logic        ld_req;
   logic        new_req;
   logic [1:0]  size;
   logic        aligned;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;

   // Load extraction (captured lane and funct3)
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_ext;

   // NOTE: every variable assigned in an always_comb block gets a default at
   // the top. If one path leaves a variable unassigned, the tool infers a latch.
   always_comb begin
      st_req     = mem_write[2];
      ld_req     = mem_read[3] & ~st_req;   // a store takes priority over a load
      new_req    = st_req | ld_req;
      // Load funct3[1:0] uses the same size encoding as the store field.
      // Code 11 falls through to word handling.
      size       = st_req ? mem_write[1:0] : mem_read[1:0];
      aligned    = 1'b1;
      be_calc    = 4'b1111;
      wdata_calc = write_data;
      case (size)
         2'b00: begin
            aligned    = 1'b1;
            be_calc    = 4'b0001 << address[1:0];
            wdata_calc = {4{write_data[7:0]}};
         end
         2'b01: begin
            aligned    = ~address[0];
            be_calc    = address[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{write_data[15:0]}};
         end
         default: begin
            aligned    = (address[1:0] == 2'b00);
            be_calc    = 4'b1111;
            wdata_calc = write_data;
         end
      endcase
   end

   always_comb begin
      sel_byte = mem_rdata[7:0];
      case (lane_q)
         2'd0:    sel_byte = mem_rdata[7:0];
         2'd1:    sel_byte = mem_rdata[15:8];
         2'd2:    sel_byte = mem_rdata[23:16];
         default: sel_byte = mem_rdata[31:24];
      endcase
      sel_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

      case (funct3_q)
         3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
         3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
         3'b100:  load_ext = {24'h0, sel_byte};
         3'b101:  load_ext = {16'h0, sel_half};
         default: load_ext = mem_rdata;         // LW and unused encodings
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d       = state_q;
      read_data_d   = read_data_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_byte_en_d = mem_byte_en_q;
      mem_wdata_d   = mem_wdata_q;
      funct3_d      = funct3_q;
      lane_d        = lane_q;
      count_d       = count_q;
      bus_err_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (new_req && aligned) begin
               state_d       = S_ACCESS;
               mem_req_d     = 1'b1;
               mem_we_d      = st_req;
               mem_addr_d    = address[31:2];
               mem_byte_en_d = be_calc;
               mem_wdata_d   = wdata_calc;
               funct3_d      = st_req ? 3'b010 : mem_read[2:0];
               lane_d        = address[1:0];
               count_d       = 8'd0;
            end
         end

         S_ACCESS: begin
            // An ack on the final permitted cycle still completes the access.
            if (mem_ack) begin
               if (!mem_we_q) begin
                  read_data_d = load_ext;
               end
               state_d   = S_DONE;
               mem_req_d = 1'b0;
            end else if (count_q == LAST_COUNT) begin
               state_d   = S_DONE;
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;              // registered, so it shows in DONE
            end else begin
               count_d = count_q + 8'd1;
            end
         end

         S_DONE: begin
            // The instruction that is completing is still on the inputs here.
            // DONE ignores the inputs and returns to IDLE unconditionally.
            state_d = S_IDLE;
            count_d = 8'd0;
         end

         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only. With blocking
   // assignments, each flop's update would depend on the order of the statements.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         read_data_q   <= 32'h0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= 30'h0;
         mem_byte_en_q <= 4'h0;
         mem_wdata_q   <= 32'h0;
         funct3_q      <= 3'b000;
         lane_q        <= 2'b00;
         count_q       <= 8'd0;
         bus_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         read_data_q   <= read_data_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_byte_en_q <= mem_byte_en_d;
         mem_wdata_q   <= mem_wdata_d;
         funct3_q      <= funct3_d;
         lane_q        <= lane_d;
         count_q       <= count_d;
         bus_err_q     <= bus_err_d;
      end
   end

   // The stall must act in the same cycle the request appears, so busy is
   // combinational. The misalignment pulse is combinational for the same
   // reason. It is held low while reset is asserted.
   assign busy           = (state_q == S_ACCESS) ||
                           ((state_q == S_IDLE) && new_req && aligned);
   assign misaligned_err = reset && (state_q == S_IDLE) && new_req && !aligned;

   assign read_data   = read_data_q;
   assign bus_err     = bus_err_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_byte_en = mem_byte_en_q;
   assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_data_mem_access_unit
//
// Directed bench for data_mem_access_unit, built with TIMEOUT_CYCLES=4.
// Inputs change 1 time unit after the rising edge. Registered outputs are
// checked at that point. Combinational outputs are checked 1 time unit after
// the inputs change. Busy and request cycles are counted on falling edges.
// -----------------------------------------------------------------------------
module tb_data_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  mem_read;
   logic [2:0]  mem_write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        busy;
   logic        misaligned_err;
   logic        bus_err;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_byte_en;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int checks    = 0;
   int errors    = 0;
   int busy_cnt  = 0;
   int req_cnt   = 0;

   data_mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .address        (address),
      .write_data     (write_data),
      .read_data      (read_data),
      .busy           (busy),
      .misaligned_err (misaligned_err),
      .bus_err        (bus_err),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_byte_en    (mem_byte_en),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      busy_cnt = busy_cnt + int'(busy);
      req_cnt  = req_cnt + int'(mem_req);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b0;
      mem_read   = 4'b0;
      mem_write  = 3'b0;
      address    = 32'h0;
      write_data = 32'h0;
      mem_rdata  = 32'h0;
      mem_ack    = 1'b0;

      // ---- reset state ----
      #2;
      check("rst_read_data", read_data, 32'h0);
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'h0);
      check("rst_mem_addr", 32'(mem_addr), 32'h0);
      check("rst_byte_en", 32'(mem_byte_en), 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_bus_err", 32'(bus_err), 32'h0);
      check("rst_misaligned", 32'(misaligned_err), 32'h0);
      #10 reset = 1'b1;
      tick();

      // ---- LW 0x100, ack on the 4th ACCESS cycle (== timeout boundary) ----
      mem_read = 4'b1010; address = 32'h100; busy_cnt = 0; req_cnt = 0;
      #1;
      check("lw_busy_req_cycle", 32'(busy), 32'h1);
      check("lw_no_req_yet", 32'(mem_req), 32'h0);
      tick();
      check("lw_mem_req", 32'(mem_req), 32'h1);
      check("lw_mem_addr", 32'(mem_addr), 32'h40);
      check("lw_byte_en", 32'(mem_byte_en), 32'hF);
      check("lw_mem_we", 32'(mem_we), 32'h0);
      tick();
      tick();
      tick();
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      tick();
      mem_ack = 1'b0; mem_rdata = 32'h0;
      #1;
      check("lw_done_busy", 32'(busy), 32'h0);
      check("lw_done_req", 32'(mem_req), 32'h0);
      check("lw_done_bus_err", 32'(bus_err), 32'h0);
      check("lw_read_data", read_data, 32'hDEADBEEF);
      tick();
      check("lw_busy_cycles", 32'(busy_cnt), 32'd5);
      check("lw_req_cycles", 32'(req_cnt), 32'd4);
      mem_read = 4'b0; address = 32'h0;

      // ---- LB 0x103 ----
      mem_read = 4'b1000; address = 32'h103;
      tick();
      check("lb_byte_en", 32'(mem_byte_en), 32'h8);
      mem_ack = 1'b1; mem_rdata = 32'h80112233;
      tick();
      mem_ack = 1'b0;
      check("lb_read_data", read_data, 32'hFFFFFF80);
      tick();

      // ---- LBU 0x103 ----
      mem_read = 4'b1100;
      tick();
      check("lbu_byte_en", 32'(mem_byte_en), 32'h8);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("lbu_read_data", read_data, 32'h00000080);
      tick();

      // ---- SH 0x202, immediate ack ----
      mem_read = 4'b0; mem_write = 3'b101; address = 32'h202;
      write_data = 32'h0000ABCD; busy_cnt = 0;
      #1;
      check("sh_busy_req_cycle", 32'(busy), 32'h1);
      tick();
      check("sh_mem_we", 32'(mem_we), 32'h1);
      check("sh_byte_en", 32'(mem_byte_en), 32'hC);
      check("sh_wdata", mem_wdata, 32'hABCDABCD);
      check("sh_mem_addr", 32'(mem_addr), 32'h80);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      #1;
      check("sh_done_busy", 32'(busy), 32'h0);
      check("sh_read_data_kept", read_data, 32'h80);
      tick();
      check("sh_busy_cycles", 32'(busy_cnt), 32'd2);
      mem_write = 3'b0;

      // ---- misaligned LW 0x101 ----
      mem_read = 4'b1010; address = 32'h101; req_cnt = 0;
      #1;
      check("mis_err_pulse", 32'(misaligned_err), 32'h1);
      check("mis_busy", 32'(busy), 32'h0);
      tick();
      mem_read = 4'b0;
      #1;
      check("mis_err_cleared", 32'(misaligned_err), 32'h0);
      check("mis_no_req", 32'(mem_req), 32'h0);
      check("mis_read_data", read_data, 32'h80);
      tick();
      check("mis_req_cycles", 32'(req_cnt), 32'd0);

      // ---- store and load together: store wins ----
      mem_write = 3'b110; mem_read = 4'b1010; address = 32'h300;
      write_data = 32'h11223344;
      tick();
      check("both_mem_we", 32'(mem_we), 32'h1);
      check("both_wdata", mem_wdata, 32'h11223344);
      check("both_mem_addr", 32'(mem_addr), 32'hC0);
      mem_ack = 1'b1; mem_rdata = 32'h55555555;
      tick();
      mem_ack = 1'b0;
      check("both_read_data_kept", read_data, 32'h80);
      tick();
      mem_write = 3'b0; mem_read = 4'b0;

      // ---- LH 0x102, upper half sign-extended ----
      mem_read = 4'b1001; address = 32'h102;
      tick();
      check("lh_byte_en", 32'(mem_byte_en), 32'hC);
      mem_ack = 1'b1; mem_rdata = 32'h80011234;
      tick();
      mem_ack = 1'b0;
      check("lh_read_data", read_data, 32'hFFFF8001);
      tick();

      // ---- timeout: LW 0x10, no ack ----
      mem_read = 4'b1010; address = 32'h10; req_cnt = 0;
      tick();
      tick();
      tick();
      tick();
      check("to_last_access_req", 32'(mem_req), 32'h1);
      check("to_no_err_yet", 32'(bus_err), 32'h0);
      tick();
      check("to_bus_err", 32'(bus_err), 32'h1);
      check("to_done_req", 32'(mem_req), 32'h0);
      check("to_done_busy", 32'(busy), 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      tick();
      mem_read = 4'b0;
      #1;
      check("to_err_pulse_end", 32'(bus_err), 32'h0);
      check("to_req_cycles", 32'(req_cnt), 32'd4);
      check("to_read_data_kept", read_data, 32'hFFFF8001);
      tick();
      mem_ack = 1'b0;
      check("late_ack_no_req", 32'(mem_req), 32'h0);
      check("late_ack_read_data", read_data, 32'hFFFF8001);

      // ---- reset during ACCESS ----
      mem_read = 4'b1010; address = 32'h20;
      tick();
      check("rstmid_req_before", 32'(mem_req), 32'h1);
      #2 reset = 1'b0;
      #1;
      check("rstmid_req_drop", 32'(mem_req), 32'h0);
      check("rstmid_read_data", read_data, 32'h0);
      check("rstmid_mem_addr", 32'(mem_addr), 32'h0);
      mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
      @(negedge clk);
      reset = 1'b1; mem_read = 4'b0;
      tick();
      mem_ack = 1'b0;
      check("rstmid_ack_ignored_req", 32'(mem_req), 32'h0);
      check("rstmid_ack_ignored_data", read_data, 32'h0);

      // ---- fresh SW 0x40 after reset ----
      mem_write = 3'b110; address = 32'h40; write_data = 32'hCAFEF00D; busy_cnt = 0;
      tick();
      check("sw_mem_we", 32'(mem_we), 32'h1);
      check("sw_byte_en", 32'(mem_byte_en), 32'hF);
      check("sw_wdata", mem_wdata, 32'hCAFEF00D);
      check("sw_mem_addr", 32'(mem_addr), 32'h10);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      #1;
      check("sw_done_busy", 32'(busy), 32'h0);
      check("sw_read_data", read_data, 32'h0);
      tick();
      check("sw_no_retrigger", 32'(mem_req), 32'h0);
      check("sw_busy_cycles", 32'(busy_cnt), 32'd2);
      mem_write = 3'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
